instr_encoder: RTL

Instruction encoder and program loader for the pipelined processor: accepts decoded instruction fields (op class, funct, Rd, Rn, operand/immediate, condition) over a valid/ready handshake and packs them into 32-bit machine words in the same format the control unit decodes. The words are buffered in a FIFO and written sequentially into instruction memory from a programmable base address. It sits between the test/boot host and the instruction memory write port, ahead of the fetch stage.

---
 rtl/instr_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words, buffers them
// in a FIFO and writes them sequentially into instruction memory from a base address.
//
// Ports:
//   clk, reset (async, active-low)
//   start/base_addr          : open a load session at base_addr (only from IDLE)
//   cmd_valid/cmd_ready      : command handshake; cmd_last closes the session
//   cmd_cond/op/funct/rd/rn/imm : decoded instruction fields
//   imem_ready               : memory accepts a write this cycle
//   imem_we/addr/wdata       : registered memory write port
//   busy, done, word_count, err, wrap : session status
//
// Build option: define ENC_CHECK_EN to drop illegal commands (op=11, or a
// data-processing funct[4:1] outside the supported set) and flag them on err.
// Without it every command is packed verbatim and err stays 0.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_last,
    input  logic [3:0]        cmd_cond,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_funct,
    input  logic [3:0]        cmd_rd,
    input  logic [3:0]        cmd_rn,
    input  logic [23:0]       cmd_imm,
    input  logic              imem_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic              wrap
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d, enc_word;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              imem_we_q, imem_we_d, done_q, done_d;
    logic              err_q, err_d, wrap_q, wrap_d;
    logic              accept, illegal, push, pop, begin_s;

    always_comb enc_word = (cmd_op == 2'b10)
        ? {cmd_cond, 2'b10, cmd_funct[5:4], cmd_imm}
        : {cmd_cond, cmd_op, cmd_funct, cmd_rn, cmd_rd, cmd_imm[11:0]};

`ifdef ENC_CHECK_EN
    assign illegal = (cmd_op == 2'b11) || ((cmd_op == 2'b00) && !(cmd_funct[4:1] inside
        {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b0011, 4'b0101, 4'b0111}));
`else
    assign illegal = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (accept && cmd_last) ? DRAIN : RUN;
            DRAIN:   state_d = (cnt_q == '0) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // state-decoded outputs; a same-cycle pop does not free a slot for cmd_ready
    always_comb begin
        cmd_ready = (state_q == RUN) && (cnt_q < FULL);
        busy      = (state_q != IDLE);
    end

    assign accept  = cmd_valid && cmd_ready;
    assign push    = accept && !illegal;
    assign pop     = (state_q != IDLE) && (cnt_q != '0) && imem_ready;
    assign begin_s = (state_q == IDLE) && start;

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d        = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        addr_cnt_d   = begin_s ? base_addr : (pop ? addr_cnt_q + ADDR_W'(1) : addr_cnt_q);
        word_count_d = begin_s ? '0 : (pop ? word_count_q + (ADDR_W+1)'(1) : word_count_q);
        err_d        = begin_s ? 1'b0 : (err_q || (accept && illegal));
        wrap_d       = begin_s ? 1'b0 : (wrap_q || (pop && (&addr_cnt_q)));
        imem_we_d    = pop;
        imem_addr_d  = pop ? addr_cnt_q : imem_addr_q;
        imem_wdata_d = pop ? mem[rd_ptr_q] : imem_wdata_q;
        done_d       = (state_q == DRAIN) && (cnt_q == '0);
    end

    // FIFO storage needs no reset: the pointers/count define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= enc_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            addr_cnt_q   <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            done_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            addr_cnt_q   <= addr_cnt_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            done_q       <= done_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign word_count = word_count_q;
    assign err        = err_q;
    assign wrap       = wrap_q;
    assign done       = done_q;
endmodule
